// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM burst controller.
package sram_pkg;

  localparam int unsigned ROWS_DEF      = 16;
  localparam int unsigned COLS_DEF      = 8;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned READ_LAT_DEF  = 2;
  localparam int unsigned AW_DEF        = $clog2(ROWS_DEF);
  localparam int unsigned LW_DEF        = (MAX_BURST_DEF > 1) ? $clog2(MAX_BURST_DEF) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrWait,
    StWrStrobe,
    StRdStrobe,
    StRdWait,
    StRdCapture
  } state_e;

  // Command as seen at the accept edge; sized for the default geometry.
  typedef struct packed {
    logic              write;
    logic [AW_DEF-1:0] addr;
    logic [LW_DEF-1:0] len;
  } cmd_t;

  // Address increment that wraps at the last word line, also for non power-of-two ROWS.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned rows);
    return (a + 1 >= rows) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/sram_deser.sv
// Serial-to-parallel word assembler with full and sticky overflow flags.
module sram_deser #(
  parameter int unsigned COLS = 8
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            i_shift,
  input  logic            i_serial,
  input  logic            i_consume,
  output logic [COLS-1:0] o_sreg,
  output logic            o_full,
  output logic            o_overflow
);

  localparam int unsigned CW = $clog2(COLS + 1);

  logic [COLS-1:0] r_sreg;
  logic [CW-1:0]   r_bit_cnt;
  logic            r_overflow;
  logic            w_full;

  assign w_full = (r_bit_cnt == CW'(COLS));

  // Shift in MSB-first; a consume frees the word, and a same-cycle bit starts the next one.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (i_consume) begin
      if (i_shift) begin
        r_sreg    <= {r_sreg[COLS-2:0], i_serial};
        r_bit_cnt <= CW'(1);
      end else begin
        r_bit_cnt <= '0;
      end
    end else if (i_shift) begin
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_sreg    <= {r_sreg[COLS-2:0], i_serial};
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  assign o_sreg     = r_sreg;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst write/read front-end for the SRAM macro: command FSM, address walk, read capture.
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned READ_LAT  = READ_LAT_DEF,
  localparam int unsigned AW = $clog2(ROWS),
  localparam int unsigned LW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            serial_in,
  input  logic            shift,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  output logic            word_full,
  output logic            busy,
  output logic            data_valid,
  output logic [COLS-1:0] data_out,
  output logic            err_overflow,
  output logic            mem_we,
  output logic            mem_re,
  output logic [AW-1:0]   mem_addr,
  output logic [COLS-1:0] mem_din,
  input  logic [COLS-1:0] mem_dout
);

  localparam int unsigned WCW      = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
  localparam int unsigned WAIT_END = (READ_LAT > 1) ? READ_LAT - 2 : 0;

  state_e          r_state, w_state_next;
  cmd_t            w_cmd;
  logic            w_accept;
  logic            w_strobe;
  logic            w_full;
  logic            w_overflow;
  logic [COLS-1:0] w_sreg;
  logic [AW-1:0]   w_addr_inc;
  logic [AW-1:0]   r_addr;       // address of the next word to strobe
  logic [AW-1:0]   r_last_addr;  // address of the most recent strobe
  logic [LW-1:0]   r_left;       // words remaining after the current one
  logic [WCW-1:0]  r_wait_cnt;
  logic            r_data_valid;
  logic [COLS-1:0] r_data_out;

  assign w_cmd      = '{write: cmd_write, addr: AW_DEF'(cmd_addr), len: LW_DEF'(cmd_len)};
  assign w_accept   = cmd_valid && (r_state == StIdle);
  assign w_strobe   = (r_state == StWrStrobe) || (r_state == StRdStrobe);
  assign w_addr_inc = AW'(wrap_inc(32'(r_addr), ROWS));

  sram_deser #(
    .COLS(COLS)
  ) u_deser (
    .clk       (clk),
    .arst      (arst),
    .i_shift   (shift),
    .i_serial  (serial_in),
    .i_consume (mem_we),
    .o_sreg    (w_sreg),
    .o_full    (w_full),
    .o_overflow(w_overflow)
  );

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_cmd.write ? StWrWait : StRdStrobe;
        end
      end
      StWrWait: begin
        if (w_full) begin
          w_state_next = StWrStrobe;
        end
      end
      StWrStrobe:  w_state_next = (r_left == '0) ? StIdle : StWrWait;
      StRdStrobe:  w_state_next = (READ_LAT == 1) ? StRdCapture : StRdWait;
      StRdWait: begin
        if (r_wait_cnt == WCW'(WAIT_END)) begin
          w_state_next = StRdCapture;
        end
      end
      StRdCapture: w_state_next = (r_left == '0) ? StIdle : StRdStrobe;
      default:     w_state_next = StIdle;
    endcase
  end

  // Burst bookkeeping: latch command, walk the address, count words and wait cycles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_left      <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= AW'(w_cmd.addr);
        r_left <= LW'(w_cmd.len);
      end
      if (w_strobe) begin
        r_addr      <= w_addr_inc;
        r_last_addr <= r_addr;
      end
      if (((r_state == StWrStrobe) || (r_state == StRdCapture)) && (r_left != '0)) begin
        r_left <= r_left - LW'(1);
      end
      r_wait_cnt <= (r_state == StRdWait) ? r_wait_cnt + WCW'(1) : '0;
    end
  end

  // Read capture; data_valid pulses the cycle after the capture state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_data_valid <= (r_state == StRdCapture);
      if (r_state == StRdCapture) begin
        r_data_out <= mem_dout;
      end
    end
  end

  assign cmd_ready    = (r_state == StIdle);
  assign busy         = !cmd_ready;
  assign word_full    = w_full;
  assign err_overflow = w_overflow;
  assign data_valid   = r_data_valid;
  assign data_out     = r_data_out;
  assign mem_we       = (r_state == StWrStrobe);
  assign mem_re       = (r_state == StRdStrobe);
  assign mem_addr     = w_strobe ? r_addr : r_last_addr;
  assign mem_din      = mem_we ? w_sreg : '0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: vector table of bursts, scoreboarded macro writes and reads.
module tb_sram_burst_ctrl;

  localparam int ROWS      = 16;
  localparam int COLS      = 8;
  localparam int MAX_BURST = 4;
  localparam int READ_LAT  = 2;

  logic       clk;
  logic       arst;
  logic       serial_in;
  logic       shift;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [1:0] cmd_len;
  logic       word_full;
  logic       busy;
  logic       data_valid;
  logic [7:0] data_out;
  logic       err_overflow;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  sram_burst_ctrl #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .MAX_BURST(MAX_BURST),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .serial_in   (serial_in),
    .shift       (shift),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .word_full   (word_full),
    .busy        (busy),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .err_overflow(err_overflow),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Macro model: word at addr reads back as addr ^ 8'hF0, READ_LAT cycles after mem_re.
  logic [7:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_re ? ({4'h0, mem_addr} ^ 8'hF0) : 8'h00;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[READ_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int n_re     = 0;

  logic [11:0] wr_q [$];  // {addr, data}
  logic [7:0]  rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe / read result is matched against the queued expectation.
  logic [11:0] mon_w;
  logic [7:0]  mon_r;
  always @(negedge clk) begin
    if (!arst) begin
      if (mem_we || mem_re) check("we_re_exclusive", 32'(mem_we & mem_re), 32'(0));
      if (mem_re) n_re++;
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got mem_we at addr %0h, expected none", mem_addr);
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_w[11:8]));
          check("wr_data", 32'(mem_din), 32'(mon_w[7:0]));
        end
      end
      if (data_valid) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got data_valid with %0h, expected none", data_out);
        end else begin
          mon_r = rd_q.pop_front();
          check("rd_data", 32'(data_out), 32'(mon_r));
        end
      end
    end
  end

  typedef struct packed {
    logic            wr;
    logic [3:0]      addr;
    logic [1:0]      len;
    logic [3:0][7:0] data;      // write words, or expected read words
    logic [3:0][3:0] exp_addr;  // expected strobe addresses
  } vec_t;

  vec_t vecs [6];

  task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [1:0] l);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = COLS - 1; i >= 0; i--) begin
      serial_in = w[i];
      shift     = 1'b1;
      @(posedge clk);
      #1;
    end
    shift = 1'b0;
  endtask

  // Returns at the negedge inside the write-strobe cycle, or reports a timeout.
  task automatic wait_we(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_we;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no mem_we in 20 cycles, expected one", name);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    if (v.wr) begin
      do_cmd(1'b1, v.addr, v.len);
      for (int w = 0; w <= int'(v.len); w++) begin
        wr_q.push_back({v.exp_addr[w], v.data[w]});
        shift_word(v.data[w]);
        wait_we("vec_we");
        check("busy_in_strobe", 32'(busy), 32'(1));
        @(negedge clk);
        check("word_full_after_strobe", 32'(word_full), 32'(0));
        if (w == int'(v.len)) check("ready_after_burst", 32'(cmd_ready), 32'(1));
        else check("busy_between_words", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
      end
    end else begin
      for (int w = 0; w <= int'(v.len); w++) rd_q.push_back(v.data[w]);
      do_cmd(1'b0, v.addr, v.len);
      k = 0;
      // n counts clock periods after the accept edge.
      for (int n = 1; n <= (int'(v.len) + 1) * 3 + 4; n++) begin
        @(negedge clk);
        if (data_valid) begin
          check("rd_pulse_cycle", 32'(n), 32'(4 + 3 * k));
          k++;
        end
      end
      check("rd_pulse_count", 32'(k), 32'(int'(v.len) + 1));
      check("ready_after_read", 32'(cmd_ready), 32'(1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_word_full"}, 32'(word_full), 32'(0));
    check({tag, "_data_valid"}, 32'(data_valid), 32'(0));
    check({tag, "_data_out"}, 32'(data_out), 32'(0));
    check({tag, "_err_overflow"}, 32'(err_overflow), 32'(0));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    check({tag, "_mem_re"}, 32'(mem_re), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_mem_din"}, 32'(mem_din), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w2;
    int         re_before;

    vecs[0] = '{wr: 1'b1, addr: 4'd3,  len: 2'd0, data: {8'h00, 8'h00, 8'h00, 8'hA5},
                exp_addr: {4'd0, 4'd0, 4'd0, 4'd3}};
    vecs[1] = '{wr: 1'b1, addr: 4'd14, len: 2'd3, data: {8'h44, 8'h33, 8'h22, 8'h11},
                exp_addr: {4'd1, 4'd0, 4'd15, 4'd14}};
    vecs[2] = '{wr: 1'b0, addr: 4'd14, len: 2'd3, data: {8'hF1, 8'hF0, 8'hFF, 8'hFE},
                exp_addr: {4'd1, 4'd0, 4'd15, 4'd14}};
    vecs[3] = '{wr: 1'b0, addr: 4'd5,  len: 2'd1, data: {8'h00, 8'h00, 8'hF6, 8'hF5},
                exp_addr: {4'd0, 4'd0, 4'd6, 4'd5}};
    vecs[4] = '{wr: 1'b1, addr: 4'd15, len: 2'd1, data: {8'h00, 8'h00, 8'h3C, 8'hC3},
                exp_addr: {4'd0, 4'd0, 4'd0, 4'd15}};
    vecs[5] = '{wr: 1'b0, addr: 4'd0,  len: 2'd0, data: {8'h00, 8'h00, 8'h00, 8'hF0},
                exp_addr: {4'd0, 4'd0, 4'd0, 4'd0}};

    arst      = 1'b1;
    serial_in = 1'b0;
    shift     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("idle");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    check("no_overflow_yet", 32'(err_overflow), 32'(0));

    // Ninth bit while full: dropped, overflow sticks, buffered word still written intact.
    shift_word(8'h5A);
    check("full_after_8", 32'(word_full), 32'(1));
    serial_in = 1'b0;
    shift     = 1'b1;
    @(posedge clk);
    #1;
    shift = 1'b0;
    check("overflow_set", 32'(err_overflow), 32'(1));
    check("still_full", 32'(word_full), 32'(1));
    wr_q.push_back({4'd7, 8'h5A});
    do_cmd(1'b1, 4'd7, 2'd0);
    wait_we("ovf_we");
    @(negedge clk);
    check("overflow_sticky", 32'(err_overflow), 32'(1));
    check("ovf_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk);
    #1;

    // Bit shifted during the strobe becomes MSB of word 2; a command while busy is ignored.
    w2 = 8'hB4;
    re_before = n_re;
    wr_q.push_back({4'd9, 8'h81});
    wr_q.push_back({4'd10, w2});
    do_cmd(1'b1, 4'd9, 2'd1);
    shift_word(8'h81);
    wait_we("ovl_we0");
    serial_in = w2[7];
    shift     = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 6; i >= 0; i--) begin
      serial_in = w2[i];
      shift     = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 4'd0;
      cmd_len   = 2'd3;
      cmd_valid = (i == 4);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    shift = 1'b0;
    wait_we("ovl_we1");
    @(negedge clk);
    check("ovl_ready", 32'(cmd_ready), 32'(1));
    repeat (8) @(negedge clk);
    check("busy_cmd_ignored", 32'(n_re - re_before), 32'(0));
    check("ovl_idle", 32'(busy), 32'(0));

    // Asynchronous reset while a full word waits in WR_WAIT.
    @(posedge clk);
    #1;
    do_cmd(1'b1, 4'd2, 2'd0);
    shift_word(8'hE7);
    @(negedge clk);
    check("pre_reset_full", 32'(word_full), 32'(1));
    check("pre_reset_busy", 32'(busy), 32'(1));
    arst = 1'b1;
    #1;
    check_reset_outputs("midburst");
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    run_vec(vecs[5]);

    check("wr_queue_drained", 32'(wr_q.size()), 32'(0));
    check("rd_queue_drained", 32'(rd_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
Parametrised digital front-end controller for the mixed-signal SRAM macro, succeeding the single-word serial write/read top.
- Deserialises a serial bit stream into COLS-bit words.
- Accepts write and read commands with burst length and address auto-increment.
- Drives the macro's strobe, address and data ports, and returns read data with a configurable macro read latency.

Parameters:
ROWS, 16, number of macro word lines; address width AW = $clog2(ROWS)
COLS, 8, word width in bits
MAX_BURST, 4, maximum words per command; length field width LW = $clog2(MAX_BURST)
READ_LAT, 2, cycles from mem_re assertion to valid mem_dout (≥1)

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous active-high reset
serial_in  in  1  serial data bit, MSB of word first
shift  in  1  sample serial_in this cycle
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle, command can be accepted
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  burst start address
cmd_len  in  LW  burst length minus one
word_full  out  1  deserialiser holds a complete word
busy  out  1  burst in progress
data_valid  out  1  one-cycle pulse, data_out valid
data_out  out  COLS  read word
err_overflow  out  1  sticky: shift received while deserialiser full
mem_we  out  1  macro write strobe
mem_re  out  1  macro read strobe
mem_addr  out  AW  macro address
mem_din  out  COLS  macro write data
mem_dout  in  COLS  macro read data

Behaviour:
- Reset (async, arst=1) applies immediately to all state, including mid-burst:
  - FSM goes to IDLE; deserialiser and bit count are cleared.
  - Outputs: cmd_ready=1, word_full=0, busy=0, data_valid=0, data_out=0, err_overflow=0, mem_we=0, mem_re=0, mem_addr=0, mem_din=0.
- Deserialiser:
  - On shift=1 while not full: sreg <= {sreg[COLS-2:0], serial_in} and bit_cnt increments.
  - word_full=1 when bit_cnt==COLS.
  - shift=1 while full: bit dropped, err_overflow set (sticky until reset).
  - Shifting is allowed in any FSM state.
- Command acceptance: cmd_valid && cmd_ready. All command fields are latched at acceptance; inputs are ignored otherwise.
- Burst bookkeeping:
  - Burst length = cmd_len+1 words.
  - Address increments after each word and wraps ROWS-1 → 0 (modulo ROWS).
- cmd_ready = (state==IDLE); busy = !cmd_ready.
- FSM states: IDLE, WR_WAIT, WR_STROBE, RD_STROBE, RD_WAIT, RD_CAPTURE.
  - IDLE → WR_WAIT on a write command; IDLE → RD_STROBE on a read command.
  - WR_WAIT holds until word_full=1, then goes to WR_STROBE.
  - WR_STROBE (1 cycle):
    - mem_we=1, mem_din=sreg, mem_addr=current address.
    - Deserialiser consumed: bit_cnt cleared. If shift=1 in the same cycle, the new bit is accepted as the first bit of the next word (bit_cnt=1).
    - Then WR_WAIT if words remain, else IDLE.
  - RD_STROBE (1 cycle): mem_re=1, mem_addr=current address; then RD_WAIT.
  - RD_WAIT: lasts READ_LAT-1 cycles (zero cycles when READ_LAT=1); then RD_CAPTURE.
  - RD_CAPTURE: samples mem_dout into data_out; data_valid pulses the following cycle. Then RD_STROBE if words remain, else IDLE.
- Read timing:
  - Per-word read period = READ_LAT+1 cycles.
  - First data_valid occurs READ_LAT+2 cycles after the accept edge.
- mem_addr holds its last value outside strobes; mem_we and mem_re are never high together.
- data_out holds its value until the next capture.

Decomposition:
- Package sram_pkg: ROWS/COLS defaults, the state enum type, the command struct (write, addr, len).
- One sub-module, sram_deser: shift register, bit counter, full flag, overflow flag, consume input.

Test Plan:
- Reset then idle → cmd_ready=1, every output at its reset value; assert arst mid-WR_WAIT → FSM returns to IDLE and word_full=0 immediately.
- Shift 8'hA5 MSB-first, write addr 3, len 0 → exactly one mem_we pulse with mem_addr=3, mem_din=8'hA5; word_full clears; cmd_ready returns next cycle.
- Write burst addr 14, len 3, words 11,22,33,44 → mem_we at addresses 14, 15, 0, 1 (wrap) with matching data, in order.
- Read addr 14, len 3, model returns addr XOR 8'hF0 after READ_LAT=2 → four data_valid pulses with 8'hFE, 8'hFF, 8'hF0, 8'hF1, spaced 3 cycles apart; first pulse 4 cycles after accept.
- Ninth shift while word_full, no command → err_overflow=1 and remains 1 after a following write; sreg still holds the first word.
- Shift asserted in the WR_STROBE cycle of a 2-word burst → second word is accepted with that bit as its MSB; cmd_valid pulsed while busy → ignored (single burst only).
